axilite4_mem_slave: RTL

- Single-port 128-bit on-chip memory exposed as an AXI-Lite-4 slave.
- Sits directly downstream of the two-master AXI-Lite-4 mux and connects to its slave-side read and write buses.
- Serves one transaction at a time, either read or write.
- Chooses between read and write with round-robin priority; supports byte strobes, a configurable read latency and optional address-range checking.

---
 rtl/axilite4_mem_slave_if.sv | 35 +++
 rtl/axilite4_mem_slave.sv | 119 +++++++++++
 2 files changed

// File: rtl/axilite4_mem_slave_if.sv
// rtl/axilite4_mem_slave_if.sv - AXI-Lite-4 read/write bus bundle between mux and memory slave
interface axilite4_mem_slave_if;
    logic [31:0]  readAddr_addr;
    logic         readAddr_valid;
    logic         readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid;
    logic         readData_ready;
    logic [31:0]  writeAddr_addr;
    logic         writeAddr_valid;
    logic         writeAddr_ready;
    logic [127:0] writeData_data;
    logic [15:0]  writeData_strb;
    logic         writeData_valid;
    logic         writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid;
    logic         writeResp_ready;

    modport slave (
        input  readAddr_addr, readAddr_valid, output readAddr_ready,
        output readData_data, readData_valid, input  readData_ready,
        input  writeAddr_addr, writeAddr_valid, output writeAddr_ready,
        input  writeData_data, writeData_strb, writeData_valid, output writeData_ready,
        output writeResp_msg, writeResp_valid, input  writeResp_ready
    );

    modport master (
        output readAddr_addr, readAddr_valid, input  readAddr_ready,
        input  readData_data, readData_valid, output readData_ready,
        output writeAddr_addr, writeAddr_valid, input  writeAddr_ready,
        output writeData_data, writeData_strb, writeData_valid, input  writeData_ready,
        input  writeResp_msg, writeResp_valid, output writeResp_ready
    );
endinterface

// File: rtl/axilite4_mem_slave.sv
// rtl/axilite4_mem_slave.sv - 128-bit single-port memory AXI-Lite-4 slave, round-robin rd/wr arbitration
// Optional address range checking enabled by defining AXIL_MEM_RANGE_CHECK_EN.
module axilite4_mem_slave #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    axilite4_mem_slave_if.slave  bus
);
    localparam int         DEPTH       = 1 << DEPTH_LOG2;
    localparam int         AW          = DEPTH_LOG2 + 4;
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_RESP} state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;   // 0: read wins a collision, 1: write wins
    logic [3:0]    cnt_q, cnt_d;
    logic [127:0]  rdata_q, rdata_d;
    logic [31:0]   wmsg_q, wmsg_d;
    logic [127:0]  mem_q [DEPTH];

    logic                  rd_elig, wr_elig, rd_go, wr_go, wr_commit;
    logic                  rd_in_range, wr_in_range;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

    assign rd_idx  = bus.readAddr_addr[AW-1:4];
    assign wr_idx  = bus.writeAddr_addr[AW-1:4];
    assign rd_elig = bus.readAddr_valid;
    assign wr_elig = bus.writeAddr_valid && bus.writeData_valid;

`ifdef AXIL_MEM_RANGE_CHECK_EN
    // BASE_ADDR is aligned to the array size, so the window is just an upper-bit match.
    assign rd_in_range = (bus.readAddr_addr[31:AW]  == BASE_ADDR[31:AW]);
    assign wr_in_range = (bus.writeAddr_addr[31:AW] == BASE_ADDR[31:AW]);
    logic unused_bits;
    assign unused_bits = ^{bus.readAddr_addr[3:0], bus.writeAddr_addr[3:0], BASE_ADDR[AW-1:0]};
`else
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{bus.readAddr_addr[3:0], bus.writeAddr_addr[3:0],
                           bus.readAddr_addr[31:AW], bus.writeAddr_addr[31:AW], BASE_ADDR};
`endif

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        wmsg_d  = wmsg_q;
        rd_go   = 1'b0;
        wr_go   = 1'b0;
        case (state_q)
            IDLE: begin
                rd_go = rd_elig && (!wr_elig || !prio_q);
                wr_go = wr_elig && !rd_go;
                if (rd_go) begin
                    prio_d  = 1'b1;
                    cnt_d   = RD_CNT_INIT;
                    rdata_d = rd_in_range ? mem_q[rd_idx] : '0;
                    state_d = (RD_CNT_INIT == 4'd0) ? RD_RESP : RD_WAIT;
                end else if (wr_go) begin
                    prio_d  = 1'b0;
                    wmsg_d  = wr_in_range ? 32'd0 : 32'd2;
                    state_d = WR_RESP;
                end
            end
            RD_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (bus.readData_ready) state_d = IDLE;
            end
            WR_RESP: begin
                if (bus.writeResp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            wmsg_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            wmsg_q  <= wmsg_d;
        end
    end

    // Array has no reset; a write commits on its acceptance edge and survives a later reset.
    assign wr_commit = wr_go && wr_in_range;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < 16; b++) begin
                if (bus.writeData_strb[b]) mem_q[wr_idx][8*b +: 8] <= bus.writeData_data[8*b +: 8];
            end
        end
    end

    assign bus.readAddr_ready  = rd_go;
    assign bus.writeAddr_ready = wr_go;
    assign bus.writeData_ready = wr_go;
    assign bus.readData_valid  = (state_q == RD_RESP);
    assign bus.readData_data   = (state_q == RD_RESP) ? rdata_q : '0;
    assign bus.writeResp_valid = (state_q == WR_RESP);
    assign bus.writeResp_msg   = (state_q == WR_RESP) ? wmsg_q : '0;
endmodule
